gmii_rx_frame_checker: RTL and testbench
========================================

// Module: gmii_rx_frame_checker
// PURPOSE
//   Non-intrusive GMII receive checker between the PHY receive pins and the TSE MAC
//   GMII rx input (tse_mac_mac_gmii_connection_gmii_rx_*) of the Nios CPU system.
//   Forwards PHY bytes to the MAC with one register stage. In parallel it parses
//   preamble/SFD, computes Ethernet CRC-32 and frame length, and keeps saturating
//   per-class frame counters for link bring-up diagnostics.
// PARAMETERS
//   MIN_FRAME  64    minimum legal length in bytes, SFD excluded, FCS included
//   MAX_FRAME  1518  maximum legal length in bytes, FCS included
//   CNT_W      32    width of each statistics counter
// PORTS
//   clk_clk          in   1      GMII rx clock (125 MHz); all logic in this domain
//   reset_reset_n    in   1      async assert, active-low reset
//   phy_rx_d         in   8      PHY receive data
//   phy_rx_dv        in   1      PHY receive data valid
//   phy_rx_er        in   1      PHY receive error
//   mac_rx_d         out  8      phy_rx_d delayed 1 cycle, to MAC gmii_rx_d
//   mac_rx_dv        out  1      phy_rx_dv delayed 1 cycle, to MAC gmii_rx_dv
//   mac_rx_err       out  1      phy_rx_er delayed 1 cycle, to MAC gmii_rx_err
//   stat_clear       in   1      sync pulse: clear all counters
//   frame_done       out  1      1-cycle pulse: a frame was classified
//   frame_ok         out  1      last classified frame was good
//   frame_len        out  16     byte count of last frame after SFD, saturates at FFFF
//   cnt_good         out  CNT_W  good frames
//   cnt_crc_err      out  CNT_W  frames with FCS mismatch
//   cnt_len_err      out  CNT_W  runt or oversize frames
//   cnt_phy_err      out  CNT_W  rx_er during frame, or bad preamble/SFD
// BEHAVIOUR
//   - Reset: every output 0. FSM enters WAIT_IDLE. CRC register = FFFFFFFF. len = 0.
//   - Passthrough: mac_rx_* <= phy_rx_* every cycle. Latency 1. Never gated by errors.
//   - FSM, evaluated on the sampled phy_rx_dv/phy_rx_d:
//     WAIT_IDLE: stay while dv=1; go to IDLE when dv=0. Never counts anything.
//       This covers reset released mid-frame.
//     IDLE: dv=1 & d=55 -> PREAMBLE. dv=1 & d!=55 -> DROP.
//     PREAMBLE: dv=1 & d=55 -> stay (any number of 55 bytes).
//       dv=1 & d=D5 -> DATA; clear len, CRC=FFFFFFFF, er flag.
//       dv=1 & other byte -> DROP. dv=0 -> IDLE and classify as phy error.
//     DATA: each dv=1 byte: len+1 (saturating), CRC updated LSB-first with
//       reflected poly EDB88320. er flag set if phy_rx_er=1 with dv=1.
//       dv=0 -> IDLE and classify.
//     DROP: wait for dv=0, then -> IDLE and classify as phy error.
//   - Classification priority: er flag or preamble/SFD fault -> phy
//     > len<MIN_FRAME or len>MAX_FRAME -> len
//     > CRC register != DEBB20E3 (residue over data+FCS) -> crc
//     > good.
//   - Per classified frame, exactly one counter increments.
//   - frame_done pulses the cycle after the dv=0 sample that ended the frame.
//     frame_ok and frame_len update in that same cycle and hold until the next pulse.
//   - Counters saturate at all-ones; no wrap.
//   - stat_clear: all counters go to 0 next cycle. If a classification lands in the
//     same cycle, the matching counter goes to 1 (clear, then increment).
//   - A 1-byte frame after SFD is valid input and is classified as a len error.
//     dv=1 with er=1 in IDLE is treated as a normal start byte, not an error.
// TESTING
//   1. 7x55, D5, 60 payload bytes + correct FCS (len 64) -> mac_rx_* match input
//      1 cycle late; frame_done pulse; frame_ok=1; frame_len=64; cnt_good=1.
//   2. Same frame with last FCS byte XOR 01 -> cnt_crc_err=1, frame_ok=0,
//      all other counters 0.
//   3. 63-byte frame with valid FCS -> cnt_len_err=1.
//      1519-byte frame with valid FCS -> cnt_len_err=2.
//   4. Good 64-byte frame with phy_rx_er=1 for one mid-frame byte -> cnt_phy_err=1.
//      Frame starting 55,55,AA -> cnt_phy_err=2, no further classification
//      until dv falls.
//   5. Assert reset mid-frame; release while dv=1 -> no frame_done for that frame.
//      Next good frame -> cnt_good=1.
//   6. Preload cnt_good=all-ones, then send a good frame -> stays all-ones.
//      stat_clear in the same cycle as a good frame's frame_done -> cnt_good=1,
//      other counters 0.

Source files
------------

// File: rtl/gmii_rx_frame_checker.sv
// rtl/gmii_rx_frame_checker.sv - GMII receive passthrough with frame parse, CRC-32 check and statistics
//
// Purpose:
//   Sits between the PHY receive pins and the MAC GMII receive input. PHY bytes are
//   forwarded to the MAC through one register stage, unaltered. In parallel the
//   preamble/SFD is parsed, CRC-32 and length of each frame are computed, and each
//   frame is classified into exactly one of good / crc / len / phy with saturating
//   counters for link bring-up diagnostics.
//
// Ports:
//   clk_clk        in   GMII rx clock; all logic in this domain
//   reset_reset_n  in   asynchronous active-low reset
//   phy_rx_d/dv/er in   PHY receive data, data valid, error
//   mac_rx_d/dv/err out phy_rx_* delayed by one cycle, to the MAC
//   stat_clear     in   synchronous pulse clearing all counters
//   frame_done     out  one-cycle pulse when a frame has been classified
//   frame_ok       out  last classified frame was good
//   frame_len      out  bytes after SFD of the last frame (saturating)
//   cnt_good       out  good frames
//   cnt_crc_err    out  FCS mismatches
//   cnt_len_err    out  runt or oversize frames
//   cnt_phy_err    out  rx_er during frame, or bad preamble/SFD

module gmii_rx_frame_checker #(
  parameter int unsigned MIN_FRAME = 64,
  parameter int unsigned MAX_FRAME = 1518,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [7:0]       phy_rx_d,
  input  logic             phy_rx_dv,
  input  logic             phy_rx_er,
  output logic [7:0]       mac_rx_d,
  output logic             mac_rx_dv,
  output logic             mac_rx_err,
  input  logic             stat_clear,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [15:0]      frame_len,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_crc_err,
  output logic [CNT_W-1:0] cnt_len_err,
  output logic [CNT_W-1:0] cnt_phy_err
);

  localparam logic [31:0]      CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0]      CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0]      MIN_LEN     = 16'(MIN_FRAME);
  localparam logic [15:0]      MAX_LEN     = 16'(MAX_FRAME);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_t;

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic        er_q, er_d;

  logic [7:0]  mac_d_q;
  logic        mac_dv_q, mac_er_q;

  logic        classify, cls_phy, cls_len, cls_crc, cls_good;
  logic [15:0] report_len;

  logic        done_q, ok_q;
  logic [15:0] flen_q;
  logic        hit_good_q, hit_crc_q, hit_len_q, hit_phy_q;
  logic [CNT_W-1:0] cnt_good_q, cnt_crc_q, cnt_len_q, cnt_phy_q;

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    len_d      = len_q;
    er_d       = er_q;
    classify   = 1'b0;
    cls_phy    = 1'b0;
    cls_len    = 1'b0;
    cls_crc    = 1'b0;
    report_len = 16'd0;
    case (state_q)
      // Reset may release in the middle of a frame; never judge that frame.
      S_WAIT_IDLE: begin
        if (!phy_rx_dv) state_d = S_IDLE;
      end
      S_IDLE: begin
        // rx_er here is deliberately ignored: the byte is a normal start byte.
        if (phy_rx_dv) state_d = (phy_rx_d == 8'h55) ? S_PREAMBLE : S_DROP;
      end
      S_PREAMBLE: begin
        if (!phy_rx_dv) begin
          state_d  = S_IDLE;
          classify = 1'b1;
          cls_phy  = 1'b1;
        end else if (phy_rx_d == 8'hD5) begin
          state_d = S_DATA;
          len_d   = 16'd0;
          crc_d   = CRC_INIT;
          er_d    = 1'b0;
        end else if (phy_rx_d != 8'h55) begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (phy_rx_dv) begin
          len_d = (&len_q) ? len_q : len_q + 16'd1;
          crc_d = crc32_byte(crc_q, phy_rx_d);
          if (phy_rx_er) er_d = 1'b1;
        end else begin
          state_d    = S_IDLE;
          classify   = 1'b1;
          report_len = len_q;
          if (er_q)                                   cls_phy = 1'b1;
          else if ((len_q < MIN_LEN) || (len_q > MAX_LEN)) cls_len = 1'b1;
          else if (crc_q != CRC_RESIDUE)              cls_crc = 1'b1;
        end
      end
      S_DROP: begin
        // Preamble/SFD fault: no SFD was seen, so the reported length is 0.
        if (!phy_rx_dv) begin
          state_d  = S_IDLE;
          classify = 1'b1;
          cls_phy  = 1'b1;
        end
      end
      default: state_d = S_WAIT_IDLE;
    endcase
    cls_good = classify & ~cls_phy & ~cls_len & ~cls_crc;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= S_WAIT_IDLE;
      crc_q      <= CRC_INIT;
      len_q      <= 16'd0;
      er_q       <= 1'b0;
      mac_d_q    <= 8'd0;
      mac_dv_q   <= 1'b0;
      mac_er_q   <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      flen_q     <= 16'd0;
      hit_good_q <= 1'b0;
      hit_crc_q  <= 1'b0;
      hit_len_q  <= 1'b0;
      hit_phy_q  <= 1'b0;
      cnt_good_q <= '0;
      cnt_crc_q  <= '0;
      cnt_len_q  <= '0;
      cnt_phy_q  <= '0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      len_q    <= len_d;
      er_q     <= er_d;
      mac_d_q  <= phy_rx_d;
      mac_dv_q <= phy_rx_dv;
      mac_er_q <= phy_rx_er;

      done_q     <= classify;
      hit_good_q <= cls_good;
      hit_crc_q  <= cls_crc;
      hit_len_q  <= cls_len;
      hit_phy_q  <= cls_phy;
      if (classify) begin
        ok_q   <= cls_good;
        flen_q <= report_len;
      end

      // Counters step one cycle after classification, so a stat_clear issued
      // while frame_done is high clears first and then counts that frame.
      if (stat_clear) begin
        cnt_good_q <= hit_good_q ? CNT_ONE : '0;
        cnt_crc_q  <= hit_crc_q  ? CNT_ONE : '0;
        cnt_len_q  <= hit_len_q  ? CNT_ONE : '0;
        cnt_phy_q  <= hit_phy_q  ? CNT_ONE : '0;
      end else begin
        if (hit_good_q) cnt_good_q <= sat_inc(cnt_good_q);
        if (hit_crc_q)  cnt_crc_q  <= sat_inc(cnt_crc_q);
        if (hit_len_q)  cnt_len_q  <= sat_inc(cnt_len_q);
        if (hit_phy_q)  cnt_phy_q  <= sat_inc(cnt_phy_q);
      end
    end
  end

  assign mac_rx_d    = mac_d_q;
  assign mac_rx_dv   = mac_dv_q;
  assign mac_rx_err  = mac_er_q;
  assign frame_done  = done_q;
  assign frame_ok    = ok_q;
  assign frame_len   = flen_q;
  assign cnt_good    = cnt_good_q;
  assign cnt_crc_err = cnt_crc_q;
  assign cnt_len_err = cnt_len_q;
  assign cnt_phy_err = cnt_phy_q;

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// tb/tb_gmii_rx_frame_checker.sv - directed table-driven bench for gmii_rx_frame_checker

module tb_gmii_rx_frame_checker;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       phy_rx_d;
  logic             phy_rx_dv, phy_rx_er, stat_clear;
  logic [7:0]       mac_rx_d;
  logic             mac_rx_dv, mac_rx_err;
  logic             frame_done, frame_ok;
  logic [15:0]      frame_len;
  logic [CNT_W-1:0] cnt_good, cnt_crc_err, cnt_len_err, cnt_phy_err;

  always #4 clk = ~clk;

  gmii_rx_frame_checker #(.MIN_FRAME(64), .MAX_FRAME(1518), .CNT_W(CNT_W)) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .phy_rx_d     (phy_rx_d),
    .phy_rx_dv    (phy_rx_dv),
    .phy_rx_er    (phy_rx_er),
    .mac_rx_d     (mac_rx_d),
    .mac_rx_dv    (mac_rx_dv),
    .mac_rx_err   (mac_rx_err),
    .stat_clear   (stat_clear),
    .frame_done   (frame_done),
    .frame_ok     (frame_ok),
    .frame_len    (frame_len),
    .cnt_good     (cnt_good),
    .cnt_crc_err  (cnt_crc_err),
    .cnt_len_err  (cnt_len_err),
    .cnt_phy_err  (cnt_phy_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Passthrough and frame_done monitors.
  logic [7:0]  exp_d  = 8'd0;
  logic        exp_dv = 1'b0;
  logic        exp_er = 1'b0;
  int          pt_bad = 0;
  int          done_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_d = 8'd0; exp_dv = 1'b0; exp_er = 1'b0;
    end else begin
      exp_d = phy_rx_d; exp_dv = phy_rx_dv; exp_er = phy_rx_er;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mac_rx_d !== exp_d || mac_rx_dv !== exp_dv || mac_rx_err !== exp_er) pt_bad++;
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame construction
  logic [7:0] byte_q[$];

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic make_frame(input int len, input bit bad_fcs, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    byte_q.delete();
    c = 32'hFFFFFFFF;
    if (len < 4) begin
      for (int i = 0; i < len; i++) byte_q.push_back(8'(seed + i * 13));
    end else begin
      for (int i = 0; i < len - 4; i++) begin
        b = 8'(seed + i * 13);
        byte_q.push_back(b);
        c = crc_next(c, b);
      end
      c = ~c;
      byte_q.push_back(c[7:0]);
      byte_q.push_back(c[15:8]);
      byte_q.push_back(c[23:16]);
      byte_q.push_back(c[31:24]);
      if (bad_fcs) byte_q[len-1] = byte_q[len-1] ^ 8'h01;
    end
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(posedge clk);
    #1;
    phy_rx_dv = dv; phy_rx_d = d; phy_rx_er = er;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  // Preamble + SFD + byte_q, then one dv=0 byte ending the frame.
  task automatic send_frame(input int npre, input int er_idx, input bit first_er);
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, (i == 0) ? first_er : 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < byte_q.size(); i++) drive(1'b1, byte_q[i], (i == er_idx) ? 1'b1 : 1'b0);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_cnts(input string tag, input int g, input int c, input int l, input int p);
    check({tag, ".cnt_good"},    32'(cnt_good),    32'(g));
    check({tag, ".cnt_crc_err"}, 32'(cnt_crc_err), 32'(c));
    check({tag, ".cnt_len_err"}, 32'(cnt_len_err), 32'(l));
    check({tag, ".cnt_phy_err"}, 32'(cnt_phy_err), 32'(p));
  endtask

  typedef struct {
    int npre;
    int len;
    int er_idx;
    bit bad_fcs;
    bit exp_ok;
    int exp_len;
    int g, c, l, p;
  } vec_t;

  function automatic vec_t mk(input int npre, input int len, input int er_idx, input bit bad_fcs,
                              input bit exp_ok, input int exp_len,
                              input int g, input int c, input int l, input int p);
    vec_t v;
    v.npre = npre; v.len = len; v.er_idx = er_idx; v.bad_fcs = bad_fcs;
    v.exp_ok = exp_ok; v.exp_len = exp_len;
    v.g = g; v.c = c; v.l = l; v.p = p;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    int d0;
    string tag;

    //              npre len  er  bad ok len   g  c  l  p   (counters cumulative)
    vecs[0] = mk(7,   64,  -1, 0, 1, 64,   1, 0, 0, 0);
    vecs[1] = mk(7,   64,  -1, 1, 0, 64,   1, 1, 0, 0);
    vecs[2] = mk(7,   63,  -1, 0, 0, 63,   1, 1, 1, 0);
    vecs[3] = mk(7,   1519, -1, 0, 0, 1519, 1, 1, 2, 0);
    vecs[4] = mk(7,   64,  30, 0, 0, 64,   1, 1, 2, 1);
    vecs[5] = mk(15,  1518, -1, 0, 1, 1518, 2, 1, 2, 1);
    vecs[6] = mk(1,   65,  -1, 0, 1, 65,   3, 1, 2, 1);
    vecs[7] = mk(7,   1,   -1, 0, 0, 1,    3, 1, 3, 1);
    vecs[8] = mk(7,   63,  -1, 1, 0, 63,   3, 1, 4, 1);
    vecs[9] = mk(7,   1519, 100, 0, 0, 1519, 3, 1, 4, 2);

    // Reset state with busy inputs
    rst_n = 1'b0; stat_clear = 1'b0;
    phy_rx_dv = 1'b1; phy_rx_d = 8'hA5; phy_rx_er = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset.mac_rx_d",   32'(mac_rx_d),   32'd0);
    check("reset.mac_rx_dv",  32'(mac_rx_dv),  32'd0);
    check("reset.mac_rx_err", 32'(mac_rx_err), 32'd0);
    check("reset.frame_done", 32'(frame_done), 32'd0);
    check("reset.frame_ok",   32'(frame_ok),   32'd0);
    check("reset.frame_len",  32'(frame_len),  32'd0);
    check_cnts("reset", 0, 0, 0, 0);
    drive(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // Table-driven frames
    for (int k = 0; k < 10; k++) begin
      tag = $sformatf("vec%0d", k);
      d0 = done_cnt;
      make_frame(vecs[k].len, vecs[k].bad_fcs, k * 17 + 3);
      send_frame(vecs[k].npre, vecs[k].er_idx, 1'b0);
      idle(6);
      check({tag, ".done_pulses"}, 32'(done_cnt - d0), 32'd1);
      check({tag, ".frame_ok"},    32'(frame_ok),      32'(vecs[k].exp_ok));
      check({tag, ".frame_len"},   32'(frame_len),     32'(vecs[k].exp_len));
      check_cnts(tag, vecs[k].g, vecs[k].c, vecs[k].l, vecs[k].p);
      check({tag, ".passthrough"}, 32'(pt_bad), 32'd0);
    end

    // Bad preamble 55,55,AA: nothing classified until dv falls, even past a D5
    d0 = done_cnt;
    drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'hD5, 1'b0); drive(1'b1, 8'h10, 1'b0);
    drive(1'b1, 8'h20, 1'b0); drive(1'b1, 8'h30, 1'b0);
    check("badpre.no_early_done", 32'(done_cnt - d0), 32'd0);
    idle(6);
    check("badpre.done_pulses", 32'(done_cnt - d0), 32'd1);
    check("badpre.frame_ok",    32'(frame_ok),      32'd0);
    check_cnts("badpre", 3, 1, 4, 3);

    // First byte not 55 -> drop, phy error
    drive(1'b1, 8'h12, 1'b0); drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'hD5, 1'b0);
    idle(6);
    check_cnts("badstart", 3, 1, 4, 4);

    // rx_er on the start byte in IDLE is not an error
    make_frame(64, 1'b0, 91);
    send_frame(7, -1, 1'b1);
    idle(6);
    check("idle_er.frame_ok", 32'(frame_ok), 32'd1);
    check_cnts("idle_er", 4, 1, 4, 4);

    // Preamble cut short by dv=0 -> phy error
    d0 = done_cnt;
    drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h55, 1'b0);
    idle(6);
    check("shortpre.done_pulses", 32'(done_cnt - d0), 32'd1);
    check_cnts("shortpre", 4, 1, 4, 5);

    // Reset mid-frame, released while dv=1: that frame is never classified
    make_frame(64, 1'b0, 55);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, byte_q[i], 1'b0);
    rst_n = 1'b0;
    #1;
    check_cnts("midreset.async", 0, 0, 0, 0);
    for (int i = 20; i < 23; i++) drive(1'b1, byte_q[i], 1'b0);
    rst_n = 1'b1;
    d0 = done_cnt;
    for (int i = 23; i < 64; i++) drive(1'b1, byte_q[i], 1'b0);
    idle(6);
    check("midreset.no_done", 32'(done_cnt - d0), 32'd0);
    check("midreset.frame_ok", 32'(frame_ok), 32'd0);
    check("midreset.frame_len", 32'(frame_len), 32'd0);
    check_cnts("midreset", 0, 0, 0, 0);
    make_frame(64, 1'b0, 77);
    send_frame(7, -1, 1'b0);
    idle(6);
    check_cnts("after_reset", 1, 0, 0, 0);

    // Saturation: 14 more good frames reach all-ones, one more must hold it
    for (int i = 0; i < 14; i++) begin
      make_frame(64, 1'b0, i);
      send_frame(7, -1, 1'b0);
      idle(4);
    end
    check("sat.reach", 32'(cnt_good), 32'd15);
    d0 = done_cnt;
    make_frame(64, 1'b0, 200);
    send_frame(7, -1, 1'b0);
    idle(6);
    check("sat.done_pulses", 32'(done_cnt - d0), 32'd1);
    check("sat.hold", 32'(cnt_good), 32'd15);

    // A runt so a non-good counter is nonzero before the clear
    make_frame(10, 1'b0, 5);
    send_frame(7, -1, 1'b0);
    idle(6);
    check_cnts("preclear", 15, 0, 1, 0);

    // stat_clear in the same cycle as a good frame's frame_done
    make_frame(64, 1'b0, 123);
    send_frame(7, -1, 1'b0);
    @(posedge clk);
    #1;
    check("clear.frame_done_high", 32'(frame_done), 32'd1);
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    idle(4);
    check_cnts("clear", 1, 0, 0, 0);
    check("final.passthrough", 32'(pt_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
